// File: rtl/alu_serial.sv
// alu_serial -- bit-serial ALU: a single 1-bit slice reused over WIDTH cycles,
// LSB first, with the carry held in a flop between bit positions.
// Operations: and, or, add, slt, each with optional a/b inversion
// (b_invert also supplies the bit-0 carry-in, so a + ~b + 1 gives subtract).
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   start     request, sampled only while idle
//   a_invert  invert operand a
//   b_invert  invert operand b and carry-in to bit 0
//   op        00 and, 01 or, 10 add, 11 slt
//   a, b      operands (latched on an accepted start)
//   busy      high while an operation is in progress
//   done      one-cycle pulse; result and flags valid
//   result    registered result
//   co        carry out of the MSB adder stage
//   overflow  signed overflow of the add/sub
//   zero      result == 0
module alu_serial #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             a_invert,
   input  logic             b_invert,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             co,
   output logic             overflow,
   output logic             zero
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_ADD = 2'b10;
   localparam logic [1:0] OP_SLT = 2'b11;

   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             a_inv_q;
   logic             b_inv_q;
   logic [1:0]       op_q;
   logic             carry;
   logic [CW-1:0]    idx;
   logic [WIDTH-1:0] shreg;
   logic             cin_msb;
   logic             sum_msb;

   // Single-bit slice operating on the current LSB of the operand shifters.
   logic ai, bi, sum_bit, carry_nxt, bit_val;

   always_comb begin
      ai        = a_sh[0] ^ a_inv_q;
      bi        = b_sh[0] ^ b_inv_q;
      sum_bit   = ai ^ bi ^ carry;
      carry_nxt = (ai & bi) | (ai & carry) | (bi & carry);
      bit_val   = 1'b0;
      case (op_q)
         OP_AND:  bit_val = ai & bi;
         OP_OR:   bit_val = ai | bi;
         OP_ADD:  bit_val = sum_bit;
         OP_SLT:  bit_val = 1'b0;
         default: bit_val = 1'b0;
      endcase
   end

   // Completion: carry now holds the carry out of the MSB stage.
   logic             ovf_fin;
   logic             set_fin;
   logic [WIDTH-1:0] final_res;

   always_comb begin
      ovf_fin   = cin_msb ^ carry;
      set_fin   = sum_msb ^ ovf_fin;
      final_res = shreg;
      if (op_q == OP_SLT) begin
         final_res = {{(WIDTH-1){1'b0}}, set_fin};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         a_inv_q  <= 1'b0;
         b_inv_q  <= 1'b0;
         op_q     <= OP_AND;
         carry    <= 1'b0;
         idx      <= '0;
         shreg    <= '0;
         cin_msb  <= 1'b0;
         sum_msb  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         co       <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh    <= a;
                  b_sh    <= b;
                  a_inv_q <= a_invert;
                  b_inv_q <= b_invert;
                  op_q    <= op;
                  carry   <= b_invert;
                  idx     <= '0;
                  busy    <= 1'b1;
                  state   <= ST_RUN;
               end
            end

            ST_RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               carry <= carry_nxt;
               // New bits enter at the MSB; after WIDTH shifts bit 0 is at position 0.
               shreg <= {bit_val, shreg[WIDTH-1:1]};
               idx   <= idx + 1'b1;
               if (idx == LAST_BIT) begin
                  cin_msb <= carry;
                  sum_msb <= sum_bit;
                  state   <= ST_FIN;
               end
            end

            ST_FIN: begin
               co       <= carry;
               overflow <= ovf_fin;
               result   <= final_res;
               zero     <= (final_res == '0);
               done     <= 1'b1;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Bit-serial ALU: one 1-bit ALU slice, reused over WIDTH cycles, LSB-first.
- Same operation set and invert controls as the parallel slice-based ALU: and, or, add, slt, with a_invert/b_invert.
- Carry is held in a flop between bit positions.
- Sits beside the parallel ALU as the low-area datapath option; a start/done handshake drives it from a multi-cycle controller.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- a_invert  in  1  invert operand a.
- b_invert  in  1  invert operand b; also the carry-in to bit 0 (sub = a + ~b + 1).
- op  in  2  00 and, 01 or, 10 add, 11 slt.
- a  in  WIDTH  operand a.
- b  in  WIDTH  operand b.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; result and flags valid.
- result  out  WIDTH  registered result.
- co  out  1  carry out of the MSB adder stage.
- overflow  out  1  signed overflow of the add/sub.
- zero  out  1  result == 0.

Behaviour:
- Reset (rst=1 at an edge, any state, including mid-operation):
  - state -> IDLE; busy, done, result, co, overflow -> 0; zero -> 1.
  - Any in-flight operation is discarded.
- IDLE, start=1 at an edge:
  - Latch a, b, a_invert, b_invert, op.
  - carry flop <= b_invert; bit index <= 0; busy <= 1; go RUN.
- IDLE, start=0: hold all outputs; done <= 0.
- RUN, one bit i per cycle, i = 0..WIDTH-1:
  - ai = a[i]^a_invert; bi = b[i]^b_invert.
  - sum = ai^bi^carry; carry <= majority(ai, bi, carry).
  - Bit value: and -> ai&bi; or -> ai|bi; add -> sum; slt -> 0 (bit 0 patched in FIN).
  - The bit shifts into a result shift register from the MSB end, so after WIDTH shifts bit 0 sits at position 0.
  - At i = WIDTH-1, record carry-in to the MSB (cin_msb) and sum_msb.
  - After the WIDTH-th bit, go FIN.
- FIN, one cycle:
  - co <= carry; overflow <= cin_msb ^ carry; set = sum_msb ^ overflow.
  - result <= shift register; if op=11, result <= {WIDTH-1 zeros, set}.
  - zero <= (final result == 0).
  - done <= 1; busy <= 0; go IDLE.
- Latency:
  - start sampled at edge E0; busy high after E0.
  - done high during the cycle after edge E(WIDTH+1), for exactly one cycle; busy low in that same cycle.
- Flags:
  - co and overflow are computed for every op, because the adder always runs; they are meaningful for add/slt.
  - zero reflects the final result for every op.
- Output hold: result and flags hold their values until the next FIN or reset.
- start while busy: ignored, with no queuing.
- start in the cycle done is high: accepted (state is IDLE); back-to-back throughput is one op per WIDTH+2 cycles.
- Operand changes after E0: no effect; inputs are used only as latched.
- nor: a_invert=1, b_invert=1, op=00 gives ~a&~b; no special case.

Test Plan (WIDTH=32):
- Add: a=5, b=3, inv=00, op=10, start pulse
  -> done exactly 33 cycles after the start edge; result=8, co=0, overflow=0, zero=0.
- Sub equal: a=b=0x0000_0005, b_invert=1, op=10
  -> result=0, zero=1, co=1, overflow=0.
- Overflow: a=0x7FFF_FFFF, b=1, op=10
  -> result=0x8000_0000, overflow=1, co=0.
- SLT: a=0xFFFF_FFFF (-1), b=1, b_invert=1, op=11
  -> result=1.
- SLT overflow case: a=0x8000_0000, b=1, b_invert=1, op=11
  -> result=1 (set corrected by overflow).
- Logic ops: a=0xF0F0_1234, b=0x0FF0_FFFF
  -> op=00 gives 0x00F0_1234; op=01 gives 0xFFF0_FFFF; inv=11, op=00 (nor) gives 0x000F_0000.
- Protocol:
  - start re-asserted during RUN -> ignored; one done only.
  - rst at bit 10 -> busy=0, done never pulses, result=0, zero=1.
  - Next start after the reset -> completes normally.
  - start held high continuously -> done every 34 cycles.
